// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace dumper: record tags and controller states.
package cpu_trace_pkg;

  localparam logic [1:0] TAG_PC  = 2'd0;
  localparam logic [1:0] TAG_REG = 2'd1;
  localparam logic [1:0] TAG_END = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PC,
    ST_REG,
    ST_RUN,
    ST_END,
    ST_DONE
  } trace_state_e;

endpackage

// File: rtl/trace_rec_slot.sv
// Single-entry output register for the record stream: loads when empty,
// holds every field stable while valid, and drains on a valid/ready handshake.
module trace_rec_slot #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5,
  parameter int SNAP_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [1:0]        tag_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [SNAP_W-1:0] snap_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [1:0]        tag_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic [DATA_W-1:0] data_o,
  output logic [SNAP_W-1:0] snap_o,
  output logic              accept_o
);

  logic              r_valid;
  logic [1:0]        r_tag;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_data;
  logic [SNAP_W-1:0] r_snap;

  assign accept_o = r_valid & ready_i;

  // A load request while the slot is occupied is ignored so a pending record never changes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_snap  <= '0;
    end else if (load_i && !r_valid) begin
      r_valid <= 1'b1;
      r_tag   <= tag_i;
      r_idx   <= idx_i;
      r_data  <= data_i;
      r_snap  <= snap_i;
    end else if (accept_o) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o = r_valid;
  assign tag_o   = r_tag;
  assign idx_o   = r_idx;
  assign data_o  = r_data;
  assign snap_o  = r_snap;

endmodule

// File: rtl/cpu_trace_dumper.sv
// Run controller and architectural-state dumper: stalls the CPU, streams PC and
// register records per snapshot, releases the CPU one clock between snapshots.
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   PC      | PC record loaded / waiting for handshake
//   REG     | walking register file, one record per register
//   RUN     | CPU released for exactly one clock
//   END     | END record with snapshot count
//   DONE    | run finished, waiting for a new start
module cpu_trace_dumper
  import cpu_trace_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PC_W        = 32,
  parameter int NUM_REGS    = 32,
  parameter int MAX_SNAPS   = 30,
  parameter int HALT_DETECT = 1,
  parameter int HALT_REPEAT = 3,
  parameter int SKIP_ZERO   = 0,
  localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int SNAP_W     = $clog2(MAX_SNAPS + 1),
  localparam int HALT_W     = $clog2(HALT_REPEAT)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic [IDX_W-1:0]  rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic              cpu_stall_o,
  output logic              rec_valid_o,
  input  logic              rec_ready_i,
  output logic [1:0]        rec_tag_o,
  output logic [IDX_W-1:0]  rec_idx_o,
  output logic [DATA_W-1:0] rec_data_o,
  output logic [SNAP_W-1:0] rec_snap_o,
  output logic              busy_o,
  output logic              done_o
);

  trace_state_e      r_state, w_state_next;
  logic [IDX_W-1:0]  r_idx, w_idx_next;
  logic [SNAP_W-1:0] r_snap, w_snap_next;
  logic [HALT_W-1:0] r_halt, w_halt_next;
  logic [PC_W-1:0]   r_prev_pc, w_prev_pc_next;
  logic              r_prev_ok, w_prev_ok_next;

  logic              w_load;
  logic [1:0]        w_tag;
  logic [IDX_W-1:0]  w_rec_idx;
  logic [DATA_W-1:0] w_rec_data;
  logic              w_valid;
  logic              w_accept;
  logic              w_advance;
  logic              w_skip;
  logic              w_last_reg;
  logic              w_halted;
  logic [SNAP_W-1:0] w_snap_inc;
  logic [HALT_W-1:0] w_halt_inc;

  assign w_last_reg = (r_idx == IDX_W'(NUM_REGS - 1));
  assign w_snap_inc = (r_snap == SNAP_W'(MAX_SNAPS)) ? r_snap : r_snap + 1'b1;
  assign w_halt_inc = (r_halt == HALT_W'(HALT_REPEAT - 1)) ? r_halt : r_halt + 1'b1;
  assign w_halted   = (HALT_DETECT != 0) && (r_halt == HALT_W'(HALT_REPEAT - 1));
  assign w_skip     = (SKIP_ZERO != 0) && (rf_rdata_i == '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_snap    <= '0;
      r_halt    <= '0;
      r_prev_pc <= '0;
      r_prev_ok <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_snap    <= w_snap_next;
      r_halt    <= w_halt_next;
      r_prev_pc <= w_prev_pc_next;
      r_prev_ok <= w_prev_ok_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_snap_next    = r_snap;
    w_halt_next    = r_halt;
    w_prev_pc_next = r_prev_pc;
    w_prev_ok_next = r_prev_ok;
    w_load         = 1'b0;
    w_tag          = TAG_PC;
    w_rec_idx      = '0;
    w_rec_data     = '0;
    w_advance      = 1'b0;

    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          w_state_next   = ST_PC;
          w_idx_next     = '0;
          w_snap_next    = '0;
          w_halt_next    = '0;
          w_prev_ok_next = 1'b0;
        end
      end
      ST_PC: begin
        w_tag      = TAG_PC;
        w_rec_data = DATA_W'(pc_i);
        w_load     = !w_valid;
        if (w_accept) begin
          // The first snapshot of a run has no predecessor to compare against.
          w_halt_next    = (r_prev_ok && (pc_i == r_prev_pc)) ? w_halt_inc : '0;
          w_prev_pc_next = pc_i;
          w_prev_ok_next = 1'b1;
          w_state_next   = ST_REG;
        end
      end
      ST_REG: begin
        w_tag      = TAG_REG;
        w_rec_idx  = r_idx;
        w_rec_data = rf_rdata_i;
        if (!w_valid) begin
          w_load    = !w_skip;
          w_advance = w_skip;
        end else begin
          w_advance = w_accept;
        end
        if (w_advance) begin
          if (w_last_reg) begin
            w_idx_next   = '0;
            w_snap_next  = w_snap_inc;
            w_state_next = ((w_snap_inc == SNAP_W'(MAX_SNAPS)) || w_halted) ? ST_END : ST_RUN;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      ST_RUN: begin
        w_state_next = ST_PC;
      end
      ST_END: begin
        w_tag      = TAG_END;
        w_rec_data = DATA_W'(r_snap);
        w_load     = !w_valid;
        if (w_accept) begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  trace_rec_slot #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .SNAP_W (SNAP_W)
  ) u_slot (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (w_load),
    .tag_i    (w_tag),
    .idx_i    (w_rec_idx),
    .data_i   (w_rec_data),
    .snap_i   (r_snap),
    .ready_i  (rec_ready_i),
    .valid_o  (w_valid),
    .tag_o    (rec_tag_o),
    .idx_o    (rec_idx_o),
    .data_o   (rec_data_o),
    .snap_o   (rec_snap_o),
    .accept_o (w_accept)
  );

  assign rec_valid_o = w_valid;
  assign rf_raddr_o  = r_idx;
  assign cpu_stall_o = (r_state != ST_RUN);
  assign busy_o      = (r_state == ST_PC) || (r_state == ST_REG) ||
                       (r_state == ST_RUN) || (r_state == ST_END);
  assign done_o      = (r_state == ST_DONE);

endmodule

// File: tb/tb_cpu_trace_dumper.sv
// Bench for cpu_trace_dumper: two parameterisations, a stepping CPU model and a
// record-level reference model derived from the snapshot rules.
module tb_cpu_trace_dumper;
  import cpu_trace_pkg::*;

  localparam int NI = 2;
  localparam int HR = 3;

  typedef struct packed {
    logic [1:0]  tag;
    logic [2:0]  idx;
    logic [31:0] data;
    logic [4:0]  snap;
  } rec_t;

  typedef struct {
    int inst;
    int rmode;
    int pattern;
    int pc_start;
    int step;
    int exp_nrec;
    int exp_end;
    int exp_lows;
    bit poke;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]       rst_n, start, ready;
  logic [NI-1:0]       stall, valid, busy, done;
  logic [NI-1:0][2:0]  raddr, idx;
  logic [NI-1:0][1:0]  tag;
  logic [NI-1:0][31:0] data, rdata;
  logic [NI-1:0][4:0]  snap;
  logic [31:0]         pc_v [NI];
  logic [31:0]         regs [NI][8];

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int NR = (g == 0) ? 4 : 8;
      localparam int MS = (g == 0) ? 2 : 30;
      localparam int SZ = (g == 0) ? 0 : 1;
      localparam int IW = $clog2(NR);
      localparam int SW = $clog2(MS + 1);
      logic [IW-1:0] w_raddr, w_idx;
      logic [SW-1:0] w_snap;

      cpu_trace_dumper #(
        .DATA_W(32), .PC_W(32), .NUM_REGS(NR), .MAX_SNAPS(MS),
        .HALT_DETECT(1), .HALT_REPEAT(HR), .SKIP_ZERO(SZ)
      ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_n[g]),
        .start_i     (start[g]),
        .pc_i        (pc_v[g]),
        .rf_raddr_o  (w_raddr),
        .rf_rdata_i  (rdata[g]),
        .cpu_stall_o (stall[g]),
        .rec_valid_o (valid[g]),
        .rec_ready_i (ready[g]),
        .rec_tag_o   (tag[g]),
        .rec_idx_o   (w_idx),
        .rec_data_o  (data[g]),
        .rec_snap_o  (w_snap),
        .busy_o      (busy[g]),
        .done_o      (done[g])
      );
      assign raddr[g] = 3'(w_raddr);
      assign idx[g]   = 3'(w_idx);
      assign snap[g]  = 5'(w_snap);
      assign rdata[g] = regs[g][3'(w_raddr)];
    end
  endgenerate

  function automatic int nr_of(input int g);   return (g == 0) ? 4 : 8;  endfunction
  function automatic int ms_of(input int g);   return (g == 0) ? 2 : 30; endfunction
  function automatic int skip_of(input int g); return (g == 0) ? 0 : 1;  endfunction

  int n_tests = 0;
  int n_fail  = 0;
  int act     = 0;
  int rmode   = 0;
  int adv_cnt = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;
  int stall_lows, stab_err;
  logic [31:0] plan_pc [32];
  logic [31:0] plan_regs [32][8];
  rec_t got_q[$];
  rec_t exp_q[$];
  bit   p_valid, p_ready;
  rec_t prev_rec;

  task automatic chk(input string nm, input logic [63:0] actual, input logic [63:0] req);
    n_tests++;
    if (actual !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, actual, req);
    end
  endtask

  // Stalled CPU: state only moves at an edge where stall was low.
  initial begin
    bit adv;
    forever begin
      @(negedge clk);
      adv = !stall[act] && rst_n[act];
      @(posedge clk);
      #1;
      if (adv) begin
        adv_cnt++;
        pc_v[act] = plan_pc[(adv_cnt > 31) ? 31 : adv_cnt];
        for (int r = 0; r < 8; r++) regs[act][r] = plan_regs[(adv_cnt > 31) ? 31 : adv_cnt][r];
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int g = 0; g < NI; g++) begin
        if (g != act)        ready[g] = 1'b0;
        else if (rmode == 0) ready[g] = 1'b1;
        else if (rmode == 1) ready[g] = (cyc % 3 == 0);
        else                 ready[g] = 1'($urandom % 2);
      end
    end
  end

  initial begin
    rec_t cur;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = '{tag: tag[act], idx: idx[act], data: data[act], snap: snap[act]};
        if (valid[act] && ready[act]) got_q.push_back(cur);
        if (!stall[act]) stall_lows++;
        if (p_valid && !p_ready && valid[act] && (cur != prev_rec)) stab_err++;
        p_valid  = valid[act];
        p_ready  = ready[act];
        prev_rec = cur;
      end
    end
  end

  // Expected record stream from the snapshot plan; returns the snapshot count.
  task automatic build_exp(input int g, output int cnt);
    int halt;
    exp_q.delete();
    halt = 0;
    cnt  = 0;
    for (int s = 0; s < 31; s++) begin
      exp_q.push_back('{tag: TAG_PC, idx: 3'd0, data: plan_pc[s], snap: 5'(s)});
      halt = (s > 0 && plan_pc[s] == plan_pc[s-1]) ? halt + 1 : 0;
      for (int r = 0; r < nr_of(g); r++)
        if (!(skip_of(g) != 0 && plan_regs[s][r] == 0))
          exp_q.push_back('{tag: TAG_REG, idx: 3'(r), data: plan_regs[s][r], snap: 5'(s)});
      cnt = s + 1;
      if (cnt == ms_of(g) || halt >= HR - 1) break;
    end
    exp_q.push_back('{tag: TAG_END, idx: 3'd0, data: 32'(cnt), snap: 5'd0});
  endtask

  task automatic make_plan(input int pattern, input int pc_start, input int step);
    for (int s = 0; s < 32; s++) begin
      if (step >= 0) plan_pc[s] = 32'(pc_start + s * step);
      else           plan_pc[s] = (s == 0) ? 32'(pc_start) : plan_pc[s-1] + (($urandom % 3 == 0) ? 32'd0 : 32'd4);
      for (int r = 0; r < 8; r++) begin
        if (pattern == 0)      plan_regs[s][r] = 32'(r * 3 + 1);
        else if (pattern == 1) plan_regs[s][r] = (r == 5) ? 32'd9 : 32'd0;
        else                   plan_regs[s][r] = ($urandom % 3 == 0) ? 32'd0 : $urandom;
      end
    end
  endtask

  task automatic load_cpu(input int g);
    adv_cnt = 0;
    pc_v[g] = plan_pc[0];
    for (int r = 0; r < 8; r++) regs[g][r] = plan_regs[0][r];
  endtask

  task automatic run_case(input int g, input int rm, input bit poke, input string nm,
                          output int n_rec, output int end_data, output int lows);
    int cnt;
    int i;
    act = g;
    rmode = rm;
    load_cpu(g);
    build_exp(g, cnt);
    got_q.delete();
    stall_lows = 0;
    stab_err = 0;
    p_valid = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    chk({nm, "_start_busy_done"}, {62'd0, busy[g], done[g]}, 64'd2);
    if (poke) begin
      repeat (3) @(negedge clk);
      start[g] = 1'b1;
      @(negedge clk);
      start[g] = 1'b0;
      chk({nm, "_start_while_busy"}, {63'd0, busy[g]}, 64'd1);
    end
    for (i = 0; i < 4000; i++) begin
      if (done[g]) break;
      @(negedge clk);
    end
    mon_en = 1'b0;
    chk({nm, "_done"}, {63'd0, done[g]}, 64'd1);
    chk({nm, "_busy_at_done"}, {63'd0, busy[g]}, 64'd0);
    chk({nm, "_rec_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      n_tests++;
      if (got_q[k].tag != exp_q[k].tag || got_q[k].idx != exp_q[k].idx ||
          got_q[k].data != exp_q[k].data ||
          (exp_q[k].tag != TAG_END && got_q[k].snap != exp_q[k].snap)) begin
        n_fail++;
        $display("FAIL %s_rec[%0d] actual tag=%0d idx=%0d data=%0h snap=%0d required tag=%0d idx=%0d data=%0h snap=%0d",
                 nm, k, got_q[k].tag, got_q[k].idx, got_q[k].data, got_q[k].snap,
                 exp_q[k].tag, exp_q[k].idx, exp_q[k].data, exp_q[k].snap);
      end
    end
    chk({nm, "_stall_lows"}, 64'(stall_lows), 64'(cnt - 1));
    chk({nm, "_hold_stable"}, 64'(stab_err), 64'd0);
    n_rec    = got_q.size();
    end_data = (got_q.size() > 0) ? int'(got_q[got_q.size()-1].data) : -1;
    lows     = stall_lows;
  endtask

  initial begin
    vec_t vt[4];
    int n_rec, end_data, lows, i;

    vt[0] = '{0, 0, 0, 0, 4, 11, 2, 1, 1'b0};
    vt[1] = '{0, 1, 0, 0, 4, 11, 2, 1, 1'b1};
    vt[2] = '{1, 0, 1, 8, 0, 7, 3, 2, 1'b0};
    vt[3] = '{1, 2, 1, 0, 4, 61, 30, 29, 1'b0};

    rst_n = '0;
    start = '0;
    ready = '0;
    for (int g = 0; g < NI; g++) begin
      pc_v[g] = '0;
      for (int r = 0; r < 8; r++) regs[g][r] = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("reset_stall%0d", g), {63'd0, stall[g]}, 64'd1);
      chk($sformatf("reset_valid%0d", g), {63'd0, valid[g]}, 64'd0);
      chk($sformatf("reset_busy%0d", g),  {63'd0, busy[g]}, 64'd0);
      chk($sformatf("reset_done%0d", g),  {63'd0, done[g]}, 64'd0);
      chk($sformatf("reset_raddr%0d", g), {61'd0, raddr[g]}, 64'd0);
      chk($sformatf("reset_fields%0d", g), {22'd0, tag[g], idx[g], data[g], snap[g]}, 64'd0);
    end
    rst_n = '1;

    for (int v = 0; v < 4; v++) begin
      make_plan(vt[v].pattern, vt[v].pc_start, vt[v].step);
      run_case(vt[v].inst, vt[v].rmode, vt[v].poke, $sformatf("vec%0d", v), n_rec, end_data, lows);
      chk($sformatf("vec%0d_nrec", v), 64'(n_rec), 64'(vt[v].exp_nrec));
      chk($sformatf("vec%0d_end_data", v), 64'(end_data), 64'(vt[v].exp_end));
      chk($sformatf("vec%0d_stall_lows", v), 64'(lows), 64'(vt[v].exp_lows));
    end

    // Reset in the middle of a register walk drops the pending record.
    make_plan(0, 64, 4);
    act = 0;
    rmode = 0;
    load_cpu(0);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (i = 0; i < 200; i++) begin
      if (valid[0] && tag[0] == TAG_REG) break;
      @(negedge clk);
    end
    chk("rst_reached_reg", {63'd0, valid[0] && tag[0] == TAG_REG}, 64'd1);
    rst_n[0] = 1'b0;
    #1;
    chk("rst_valid", {63'd0, valid[0]}, 64'd0);
    chk("rst_stall", {63'd0, stall[0]}, 64'd1);
    chk("rst_busy",  {63'd0, busy[0]}, 64'd0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    run_case(0, 0, 1'b0, "after_rst", n_rec, end_data, lows);

    for (int t = 0; t < 6; t++) begin
      make_plan(2, int'($urandom_range(0, 1000)) * 4, -1);
      run_case(t % 2, 2, 1'b0, $sformatf("rand%0d", t), n_rec, end_data, lows);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
